// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or restoring divide
// on operand magnitudes, followed by one sign-fix cycle and a one-cycle DONE pulse.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        op_r;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd;
  logic              neg_res, neg_rem;

  logic              accept, load, iter, wr_res;
  logic [XLEN-1:0]   res_nxt;

  // Operand decode for a request presented on the input ports
  logic signed [XLEN-1:0] a_s, b_s;
  logic              sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  assign a_s   = data1;
  assign b_s   = data2;
  assign sgn_a = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  assign sgn_b = sgn_a && (op != OP_MULHSU);
  assign neg_a = sgn_a && (a_s < 0);
  assign neg_b = sgn_b && (b_s < 0);
  assign mag_a = cneg(data1, neg_a);
  assign mag_b = cneg(data2, neg_b);

  assign div_zero = op[2] && (data2 == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? data1 : '1;
    else          special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration step; multiply shifts right, divide shifts left
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0]   hi_step, lo_step;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc_hi, acc_lo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    hi_step  = mul_sum[XLEN:1];
    lo_step  = {mul_sum[0], acc_lo[XLEN-1:1]};
    if (op_r[2]) begin
      if (!rem_diff[XLEN]) begin
        hi_step = rem_diff[XLEN-1:0];
        lo_step = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_step = rem_sh[XLEN-1:0];
        lo_step = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign correction and half selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = cneg2({acc_hi, acc_lo}, neg_res);
    quo  = cneg(acc_lo, neg_res);
    rem  = cneg(acc_hi, neg_rem);
    if (!op_r[2]) fix_res = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else          fix_res = op_r[1] ? rem : quo;
  end

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start && !flush;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    iter      = 1'b0;
    wr_res    = 1'b0;
    res_nxt   = result;
    unique case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (special) begin
            state_nxt = S_DONE;
            wr_res    = 1'b1;
            res_nxt   = special_res;
          end else begin
            state_nxt = S_CALC;
            load      = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          iter = 1'b1;
          if (cnt == '0) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
          wr_res    = 1'b1;
          res_nxt   = fix_res;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= '0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      if (load) begin
        op_r    <= op;
        cnt     <= CNT_W'(XLEN - 1);
        acc_hi  <= '0;
        acc_lo  <= op[2] ? mag_a : mag_b;
        opnd    <= op[2] ? mag_b : mag_a;
        neg_res <= neg_a ^ neg_b;
        neg_rem <= neg_a;
      end else if (iter) begin
        cnt    <= cnt - 1'b1;
        acc_hi <= hi_step;
        acc_lo <= lo_step;
      end
      if (wr_res) result <= res_nxt;
    end
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, busy span, results, special cases, flush and reset.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data1, data2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after DONE.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int bsy);
    int n, nb;
    bit got;
    op = o; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk);
    n = 0; nb = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (busy) nb++;
      if (done) begin
        got = 1;
        check({tag, "_res"}, result, exp);
      end
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, nb, bsy);
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n, dcnt, first;
    bit got;
    logic [31:0] res;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_done",   {31'b0, done}, 32'd0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;

    run_op("mul",    MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 33);
    run_op("mulh",   MULH,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 33);
    run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 33);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 33);

    run_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33);
    run_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33);
    run_op("divu", DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 33);
    run_op("remu", REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34, 33);

    run_op("div_by0",  DIV,  32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0);
    run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run_op("remu_by0", REMU, 32'd5,        32'd0,        32'h0000_0005, 1, 0);

    // Flush during the 10th CALC cycle
    op = MUL; data1 = 32'd7; data2 = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    check("flush_done_after", {31'b0, done}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("flush_no_done", dcnt, 32'd0);
    check("flush_result_kept", result, 32'h0000_0005);

    // START while busy is ignored
    op = MUL; data1 = 32'h1234_5678; data2 = 32'h0000_0010; start = 1'b1;
    @(posedge clk);
    dcnt = 0; first = 0; res = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dcnt++;
        if (first == 0) begin
          first = i;
          res = result;
        end
      end
      if (i == 5) begin
        op = DIV; data1 = 32'd5; data2 = 32'd0; start = 1'b1;
      end
    end
    check("ign_done_count", dcnt, 32'd1);
    check("ign_lat", first, 32'd34);
    check("ign_res", res, 32'h2345_6780);

    // FLUSH together with START in IDLE drops the request
    op = DIV; data1 = 32'd5; data2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("fs_busy", {31'b0, busy}, 32'd0);
    check("fs_done", {31'b0, done}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("fs_no_done", dcnt, 32'd0);
    check("fs_result_kept", result, 32'h2345_6780);

    // Back-to-back issue in the DONE cycle
    op = MUL; data1 = 32'd7; data2 = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) got = 1;
    end
    check("b2b_first_lat", n, 32'd34);
    check("b2b_first_res", result, 32'hFFFF_FFEB);
    op = DIVU; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
    @(posedge clk);
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) got = 1;
    end
    check("b2b_second_lat", n, 32'd34);
    check("b2b_second_res", result, 32'h0000_000E);
    @(negedge clk);

    // Asynchronous reset mid-CALC
    op = DIV; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("areset_busy_before", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy",   {31'b0, busy}, 32'd0);
    check("areset_done",   {31'b0, done}, 32'd0);
    check("areset_result", result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("areset_no_done", dcnt, 32'd0);
    check("areset_result_after", result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
